tpu_result_checker: RTL and testbench

- Synthesizable self-check engine for the systolic-array TPU.
- Measures the tpu_start-to-tpu_done cycle count, then sweeps NUM_BANKS result SRAMs and matching golden SRAMs, which hold diagonal-ordered output words.
- Compares every OUT_DATA_WIDTH lane and reports pass/fail, error count and first-failure location.
- Sits beside tpu_top on the result-SRAM read ports. It replaces software comparison and adds bank masking and stop-on-first-error.

---
 rtl/tpu_result_checker.sv | 212 +++++++++++++++++++++
 tb/tb_tpu_result_checker.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_result_checker.sv
// Self-check engine for the systolic-array TPU result SRAMs.
// Measures the tpu_start -> tpu_done run length, then sweeps NUM_WORDS addresses of
// NUM_BANKS result/golden bank pairs and compares every lane bit-exactly.
// Ports:
//   clk, srstn            clock (rising edge), asynchronous active-low reset
//   tpu_start, tpu_done   TPU start pulse and completion indication
//   bank_mask             per-bank enable, latched at an accepted start
//   stop_on_first         finish at the first mismatch, latched at an accepted start
//   chk_raddr             shared read address to all result and golden banks
//   sram_rdata_res/gold   read data, bank b at slice b (1-cycle read latency)
//   chk_busy, chk_done    busy in RUN/READ, one-cycle completion pulse
//   chk_pass, err_count   verdict and mismatching (bank,word) count
//   first_err_*           location and lane mask of the first mismatch
//   cycle_count           TPU run length in cycles (saturating)
module tpu_result_checker #(
  parameter int unsigned ARRAY_SIZE     = 8,
  parameter int unsigned OUT_DATA_WIDTH = 16,
  parameter int unsigned NUM_BANKS      = 3,
  parameter int unsigned NUM_WORDS      = 15,
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned CYC_WIDTH      = 32,
  parameter int unsigned ERR_WIDTH      = 8,
  localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int unsigned WORD_W = ARRAY_SIZE * OUT_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        srstn,
  input  logic                        tpu_start,
  input  logic                        tpu_done,
  input  logic [NUM_BANKS-1:0]        bank_mask,
  input  logic                        stop_on_first,
  output logic [ADDR_WIDTH-1:0]       chk_raddr,
  input  logic [NUM_BANKS*WORD_W-1:0] sram_rdata_res,
  input  logic [NUM_BANKS*WORD_W-1:0] sram_rdata_gold,
  output logic                        chk_busy,
  output logic                        chk_done,
  output logic                        chk_pass,
  output logic [ERR_WIDTH-1:0]        err_count,
  output logic [BANK_W-1:0]           first_err_bank,
  output logic [ADDR_WIDTH-1:0]       first_err_addr,
  output logic [ARRAY_SIZE-1:0]       first_err_lane_mask,
  output logic [CYC_WIDTH-1:0]        cycle_count
);

  typedef enum logic [1:0] {StIdle, StRun, StRead, StDone} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH:0]   LastCnt  = (ADDR_WIDTH + 1)'(NUM_WORDS);

  state_e                      state_q, state_d;
  logic [NUM_BANKS-1:0]        mask_q, mask_d;
  logic                        stop_q, stop_d;
  logic [ADDR_WIDTH-1:0]       raddr_q, raddr_d;
  logic [ADDR_WIDTH-1:0]       cmp_addr_q, cmp_addr_d;
  logic [ADDR_WIDTH:0]         cnt_q, cnt_d;
  logic [CYC_WIDTH-1:0]        cycle_q, cycle_d;
  logic [ERR_WIDTH-1:0]        err_q, err_d;
  logic [BANK_W-1:0]           fbank_q, fbank_d;
  logic [ADDR_WIDTH-1:0]       faddr_q, faddr_d;
  logic [ARRAY_SIZE-1:0]       flane_q, flane_d;
  logic                        pass_q, pass_d;
  logic                        done_q, done_d;

  logic [NUM_BANKS-1:0][ARRAY_SIZE-1:0] lane_diff;
  logic [NUM_BANKS-1:0]                 bank_err;
  logic                                 cmp_valid;
  logic                                 last_cmp;
  logic                                 hit;
  logic                                 finish;
  logic [ERR_WIDTH-1:0]                 err_acc;

  for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
    for (genvar gl = 0; gl < ARRAY_SIZE; gl++) begin : g_lane
      assign lane_diff[gb][gl] =
          sram_rdata_res[gb*WORD_W + gl*OUT_DATA_WIDTH +: OUT_DATA_WIDTH] !=
          sram_rdata_gold[gb*WORD_W + gl*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
    end
    assign bank_err[gb] = mask_q[gb] & (|lane_diff[gb]);
  end

  // cnt_q counts READ cycles since T0; data for cmp_addr_q is on the bus once cnt_q >= 1.
  assign cmp_valid = (state_q == StRead) && (cnt_q != '0);
  assign last_cmp  = cmp_valid && (cnt_q == LastCnt);
  assign finish    = last_cmp || (cmp_valid && stop_q && hit);

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      stop_q     <= 1'b0;
      raddr_q    <= '0;
      cmp_addr_q <= '0;
      cnt_q      <= '0;
      cycle_q    <= '0;
      err_q      <= '0;
      fbank_q    <= '0;
      faddr_q    <= '0;
      flane_q    <= '0;
      pass_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      stop_q     <= stop_d;
      raddr_q    <= raddr_d;
      cmp_addr_q <= cmp_addr_d;
      cnt_q      <= cnt_d;
      cycle_q    <= cycle_d;
      err_q      <= err_d;
      fbank_q    <= fbank_d;
      faddr_q    <= faddr_d;
      flane_q    <= flane_d;
      pass_q     <= pass_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (tpu_start) state_d = StRun;
      StRun:          if (tpu_done) state_d = StRead;
      StRead:         if (finish) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    mask_d     = mask_q;
    stop_d     = stop_q;
    raddr_d    = raddr_q;
    cmp_addr_d = cmp_addr_q;
    cnt_d      = cnt_q;
    cycle_d    = cycle_q;
    err_d      = err_q;
    fbank_d    = fbank_q;
    faddr_d    = faddr_q;
    flane_d    = flane_q;
    pass_d     = pass_q;
    done_d     = 1'b0;
    err_acc    = err_q;
    hit        = 1'b0;

    // Lowest bank index wins the first-error capture when several fail together.
    if (cmp_valid) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (bank_err[b]) begin
          if (err_acc != '1) err_acc = err_acc + ERR_WIDTH'(1);
          if (!hit && (err_q == '0)) begin
            fbank_d = BANK_W'(b);
            faddr_d = cmp_addr_q;
            flane_d = lane_diff[b];
          end
          hit = 1'b1;
        end
      end
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (tpu_start) begin
          cycle_d = '0;
          err_d   = '0;
          fbank_d = '0;
          faddr_d = '0;
          flane_d = '0;
          pass_d  = 1'b0;
          mask_d  = bank_mask;
          stop_d  = stop_on_first;
        end
      end
      StRun: begin
        if (tpu_done) begin
          raddr_d = '0;
          cnt_d   = '0;
        end else if (cycle_q != '1) begin
          cycle_d = cycle_q + CYC_WIDTH'(1);
        end
      end
      StRead: begin
        cnt_d      = cnt_q + (ADDR_WIDTH + 1)'(1);
        cmp_addr_d = raddr_q;
        if (raddr_q != LastAddr) raddr_d = raddr_q + ADDR_WIDTH'(1);
        if (cmp_valid && stop_q && hit) begin
          err_d  = ERR_WIDTH'(1);
          done_d = 1'b1;
          pass_d = 1'b0;
        end else begin
          err_d = err_acc;
          if (last_cmp) begin
            done_d = 1'b1;
            pass_d = (err_acc == '0);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    chk_busy            = (state_q == StRun) || (state_q == StRead);
    chk_done            = done_q;
    chk_pass            = pass_q;
    chk_raddr           = raddr_q;
    err_count           = err_q;
    first_err_bank      = fbank_q;
    first_err_addr      = faddr_q;
    first_err_lane_mask = flane_q;
    cycle_count         = cycle_q;
  end

endmodule

// File: tb/tb_tpu_result_checker.sv
module tb_tpu_result_checker;
  localparam int unsigned AS  = 8;
  localparam int unsigned ODW = 16;
  localparam int unsigned NB  = 3;
  localparam int unsigned NW  = 15;
  localparam int unsigned AW  = 6;
  localparam int unsigned W   = AS * ODW;

  typedef struct packed {
    logic [31:0] off;
    logic [31:0] cyc;
    logic [3:0]  cyc4;
    logic [7:0]  err;
    logic [1:0]  fbank;
    logic [5:0]  faddr;
    logic [7:0]  flane;
    logic        pass;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          srstn, tpu_start, tpu_done, stop_on_first;
  logic [NB-1:0] bank_mask;
  logic [NB*W-1:0] sram_rdata_res, sram_rdata_gold;

  logic [AW-1:0] chk_raddr, chk_raddr4;
  logic          chk_busy, chk_done, chk_pass, chk_busy4, chk_done4, chk_pass4;
  logic [7:0]    err_count, err_count4, flane, flane4;
  logic [1:0]    fbank, fbank4;
  logic [AW-1:0] faddr, faddr4;
  logic [31:0]   cycle_count;
  logic [3:0]    cycle_count4;

  logic [W-1:0] res_mem  [NB][NW];
  logic [W-1:0] gold_mem [NB][NW];

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   t0 = 0;

  tpu_result_checker dut (
    .clk(clk), .srstn(srstn), .tpu_start(tpu_start), .tpu_done(tpu_done),
    .bank_mask(bank_mask), .stop_on_first(stop_on_first), .chk_raddr(chk_raddr),
    .sram_rdata_res(sram_rdata_res), .sram_rdata_gold(sram_rdata_gold),
    .chk_busy(chk_busy), .chk_done(chk_done), .chk_pass(chk_pass), .err_count(err_count),
    .first_err_bank(fbank), .first_err_addr(faddr), .first_err_lane_mask(flane),
    .cycle_count(cycle_count)
  );

  tpu_result_checker #(.CYC_WIDTH(4)) dut4 (
    .clk(clk), .srstn(srstn), .tpu_start(tpu_start), .tpu_done(tpu_done),
    .bank_mask(bank_mask), .stop_on_first(stop_on_first), .chk_raddr(chk_raddr4),
    .sram_rdata_res(sram_rdata_res), .sram_rdata_gold(sram_rdata_gold),
    .chk_busy(chk_busy4), .chk_done(chk_done4), .chk_pass(chk_pass4), .err_count(err_count4),
    .first_err_bank(fbank4), .first_err_addr(faddr4), .first_err_lane_mask(flane4),
    .cycle_count(cycle_count4)
  );

  // Synchronous SRAM model, one-cycle read latency.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      sram_rdata_res[b*W +: W]  <= (int'(chk_raddr) < NW) ? res_mem[b][int'(chk_raddr)] : '0;
      sram_rdata_gold[b*W +: W] <= (int'(chk_raddr) < NW) ? gold_mem[b][int'(chk_raddr)] : '0;
    end
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_mem();
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < NW; a++) begin
        for (int i = 0; i < W / 32; i++) gold_mem[b][a][32*i +: 32] = $urandom();
        res_mem[b][a] = gold_mem[b][a];
      end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, chk_busy, 0);
    chk({tag, "_done"}, chk_done, 0);
    chk({tag, "_pass"}, chk_pass, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_fbank"}, fbank, 0);
    chk({tag, "_faddr"}, faddr, 0);
    chk({tag, "_flane"}, flane, 0);
    chk({tag, "_cyc"}, cycle_count, 0);
    chk({tag, "_raddr"}, chk_raddr, 0);
    chk({tag, "_dut4_all"},
        {chk_busy4, chk_done4, chk_pass4, err_count4, fbank4, faddr4, flane4, cycle_count4,
         chk_raddr4}, 0);
  endtask

  function automatic exp_t model(input logic [NB-1:0] mask, input logic stop);
    exp_t e;
    logic found;
    logic [7:0] lm;
    e = '0;
    e.off = NW + 1;
    found = 1'b0;
    for (int a = 0; a < NW; a++) begin
      if (!(stop && found)) begin
        for (int b = 0; b < NB; b++) begin
          if (mask[b] && (res_mem[b][a] !== gold_mem[b][a])) begin
            for (int l = 0; l < AS; l++)
              lm[l] = res_mem[b][a][l*ODW +: ODW] !== gold_mem[b][a][l*ODW +: ODW];
            if (!found) begin
              e.fbank = 2'(b);
              e.faddr = 6'(a);
              e.flane = lm;
            end
            found = 1'b1;
            if (e.err != 8'hFF) e.err = e.err + 8'd1;
          end
        end
        if (stop && found) begin
          e.err = 8'd1;
          e.off = a + 2;
        end
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  // Start at edge S, tpu_done sampled at edge S+k (= T0); optionally done also high at S.
  task automatic start_run(input logic [NB-1:0] mask, input logic stop, input int k,
                           input logic both);
    exp_t e;
    bank_mask = mask;
    stop_on_first = stop;
    tpu_start = 1'b1;
    tpu_done = both;
    e = model(mask, stop);
    e.cyc = k - 1;
    e.cyc4 = (k - 1 > 15) ? 4'hF : 4'(k - 1);
    exp_q.push_back(e);
    step();
    tpu_start = 1'b0;
    tpu_done = 1'b0;
    if (both) chk("both_busy", chk_busy, 1);
    for (int i = 1; i < k; i++) begin
      step();
      if (both && i == 1) chk("both_cyc1", cycle_count, 1);
    end
    tpu_done = 1'b1;
    step();
    tpu_done = 1'b0;
    t0 = edge_cnt;
  endtask

  task automatic wait_done();
    exp_t e;
    int n;
    n = edge_cnt - t0;
    while (chk_done !== 1'b1 && n < 40) begin
      chk("raddr", chk_raddr, (n < NW - 1) ? n : NW - 1);
      step();
      n = edge_cnt - t0;
    end
    e = exp_q.pop_front();
    chk("done_edge", n, e.off);
    chk("cycle_count", cycle_count, e.cyc);
    chk("cycle_count4", cycle_count4, e.cyc4);
    chk("err_count", err_count, e.err);
    chk("err_count4", err_count4, e.err);
    chk("first_err_bank", fbank, e.fbank);
    chk("first_err_addr", faddr, e.faddr);
    chk("first_err_lane_mask", flane, e.flane);
    chk("chk_pass", chk_pass, e.pass);
    chk("chk_pass4", chk_pass4, e.pass);
    step();
    chk("done_pulse", chk_done, 0);
    chk("busy_after", chk_busy, 0);
    chk("pass_held", chk_pass, e.pass);
    chk("err_held", err_count, e.err);
  endtask

  initial begin
    logic seen_done;
    srstn = 1'b0;
    tpu_start = 1'b0;
    tpu_done = 1'b0;
    bank_mask = '0;
    stop_on_first = 1'b0;
    fill_mem();
    #2;
    chk_zero("reset");
    step();
    step();
    srstn = 1'b1;
    step();
    chk_zero("idle");

    // 1: all banks clean, 100-cycle run
    start_run(3'b111, 1'b0, 100, 1'b0);
    wait_done();

    // 2: bank1 addr5 lane3, bank2 addr9 lanes 0 and 7
    res_mem[1][5][3*ODW +: ODW] = res_mem[1][5][3*ODW +: ODW] ^ 16'h0040;
    res_mem[2][9][0 +: ODW]     = res_mem[2][9][0 +: ODW] ^ 16'h0001;
    res_mem[2][9][7*ODW +: ODW] = res_mem[2][9][7*ODW +: ODW] ^ 16'h8000;
    start_run(3'b111, 1'b0, 20, 1'b0);
    wait_done();

    // 3: same data, stop on first
    start_run(3'b111, 1'b1, 20, 1'b0);
    wait_done();

    // 4a: only masked-out bank corrupted
    fill_mem();
    res_mem[1][4][2*ODW +: ODW] = res_mem[1][4][2*ODW +: ODW] ^ 16'h1234;
    start_run(3'b101, 1'b0, 10, 1'b0);
    wait_done();

    // 4b: banks 0 and 2 fail at the same address
    fill_mem();
    res_mem[0][3][5*ODW +: ODW] = res_mem[0][3][5*ODW +: ODW] ^ 16'h0100;
    res_mem[2][3][1*ODW +: ODW] = res_mem[2][3][1*ODW +: ODW] ^ 16'h0002;
    start_run(3'b111, 1'b0, 10, 1'b0);
    wait_done();

    // 5a: start pulse mid-READ with different mask/stop must be ignored
    start_run(3'b111, 1'b0, 12, 1'b0);
    step();
    step();
    bank_mask = 3'b000;
    stop_on_first = 1'b1;
    tpu_start = 1'b1;
    step();
    tpu_start = 1'b0;
    bank_mask = 3'b111;
    stop_on_first = 1'b0;
    wait_done();

    // 5b: reset while reading address 7
    start_run(3'b111, 1'b0, 12, 1'b0);
    void'(exp_q.pop_back());
    repeat (7) step();
    chk("raddr_before_reset", chk_raddr, 7);
    srstn = 1'b0;
    #1;
    chk_zero("midreset");
    step();
    srstn = 1'b1;
    seen_done = 1'b0;
    repeat (20) begin
      step();
      if (chk_done === 1'b1) seen_done = 1'b1;
    end
    chk("no_done_after_reset", seen_done, 0);
    chk("idle_after_reset", chk_busy, 0);

    // 5c: fresh run after reset
    fill_mem();
    start_run(3'b111, 1'b0, 100, 1'b0);
    wait_done();

    // 6: from IDLE, start and done together; 40-cycle run saturates the 4-bit counter
    srstn = 1'b0;
    step();
    srstn = 1'b1;
    step();
    start_run(3'b111, 1'b0, 40, 1'b1);
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
